jk_excitation_driver: RTL and testbench

- Stimulus-side counterpart to a bank of JK flip-flops: accepts a stream of desired next-state vectors and uses the JK excitation table to generate the j/k inputs that drive the bank to each vector.
- Buffers targets in a small FIFO, tracks the expected flop state, and compares the flop feedback against it, flagging mismatches.
- Sits between a pattern source and a JK bank in self-checking flip-flop test structures.

---
 rtl/jk_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/jk_excitation_driver.sv | 196 +++++++++++++++++++
 tb/tb_jk_excitation_driver.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared types and helpers for the JK excitation driver.
//   state_t   : controller states (IDLE, RUN, DRAIN, HALT)
//   jk_excite : JK excitation table, one bit, returns {j, k}
//   ERR_CNT_W : width of the saturating failure counter
package jk_pkg;

   localparam int ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      HALT  = 2'b11
   } state_t;

   // Excitation for one flop going from current state m to target t.
   // dc is driven on whichever input the table leaves unconstrained.
   function automatic logic [1:0] jk_excite(input logic m, input logic t, input logic dc);
      logic [1:0] jk_s;
      case ({m, t})
         2'b00:   jk_s = {1'b0, dc};
         2'b01:   jk_s = {1'b1, dc};
         2'b10:   jk_s = {dc, 1'b1};
         2'b11:   jk_s = {dc, 1'b0};
         default: jk_s = 2'b00;
      endcase
      return jk_s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO holding target vectors.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared)
//   push, push_data : write request and data (ignored when full)
//   pop, pop_data   : read request (ignored when empty); pop_data shows the head
//   full, empty     : status, derived from pointers with an extra wrap bit
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;

   // Wrap bits differ with equal indices: writer is a full lap ahead.
   assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty    = (wr_ptr_r == rd_ptr_r);
   assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

   // Storage and pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
            wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns a stream of target vectors into registered J/K
// drives for a JK flop bank and checks the bank's feedback two edges later.
//   clk, rst_n      : clock shared with the bank, asynchronous active-low reset
//   tgt_valid/data  : target vector offered; accepted when tgt_ready is high
//   tgt_ready       : FIFO not full
//   q_fb            : q outputs of the JK bank
//   j, k            : registered drives (zero in any cycle without a pop)
//   busy, halted    : RUN/DRAIN, HALT state indicators
//   mismatch        : one-cycle pulse on a failed compare
//   mismatch_mask   : differing bits of the most recent failure
//   err_count       : saturating failure count
module jk_excitation_driver
   import jk_pkg::*;
#(
   parameter int   WIDTH       = 4,
   parameter int   DEPTH       = 4,
   parameter logic DC_VAL      = 1'b0,
   parameter logic STOP_ON_ERR = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tgt_valid,
   input  logic [WIDTH-1:0]     tgt_data,
   output logic                 tgt_ready,
   input  logic [WIDTH-1:0]     q_fb,
   output logic [WIDTH-1:0]     j,
   output logic [WIDTH-1:0]     k,
   output logic                 busy,
   output logic                 halted,
   output logic                 mismatch,
   output logic [WIDTH-1:0]     mismatch_mask,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t               state_r;
   state_t               state_nxt_s;
   logic                 full_s;
   logic                 empty_s;
   logic [WIDTH-1:0]     head_s;
   logic                 push_s;
   logic                 pop_s;
   logic [WIDTH-1:0]     exc_j_s;
   logic [WIDTH-1:0]     exc_k_s;
   logic [WIDTH-1:0]     q_model_r;
   logic [WIDTH-1:0]     j_r;
   logic [WIDTH-1:0]     k_r;
   logic                 v0_r;
   logic                 v1_r;
   logic [WIDTH-1:0]     exp0_r;
   logic [WIDTH-1:0]     exp1_r;
   logic                 pending_s;
   logic                 cmp_fail_s;
   logic                 mismatch_r;
   logic [WIDTH-1:0]     mask_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;

   assign tgt_ready = !full_s;
   assign push_s    = tgt_valid && !full_s;
   assign pop_s     = (state_r == RUN) && !empty_s;
   assign pending_s = v0_r || v1_r;
   // Stage 1 holds the value the bank should show after its update edge.
   assign cmp_fail_s = v1_r && (q_fb != exp1_r);

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (tgt_data),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   // Per-bit excitation from the modelled flop state to the FIFO head
   always_comb begin
      exc_j_s = '0;
      exc_k_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {exc_j_s[i], exc_k_s[i]} = jk_excite(q_model_r[i], head_s[i], DC_VAL);
      end
   end

   // Controller next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (cmp_fail_s && STOP_ON_ERR) begin
               state_nxt_s = HALT;
            end else if (!empty_s || push_s) begin
               state_nxt_s = RUN;
            end else if (pending_s) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DRAIN: begin
            if (cmp_fail_s && STOP_ON_ERR) begin
               state_nxt_s = HALT;
            end else if (push_s || !empty_s) begin
               state_nxt_s = RUN;
            end else if (!pending_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         HALT: begin
            state_nxt_s = HALT;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Drive registers and flop-state model; drives fall to zero without a pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j_r       <= '0;
         k_r       <= '0;
         q_model_r <= '0;
      end else if (pop_s) begin
         j_r       <= exc_j_s;
         k_r       <= exc_k_s;
         q_model_r <= head_s;
      end else begin
         j_r <= '0;
         k_r <= '0;
      end
   end

   // Two-stage expected-value pipeline aligned with the bank update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_r   <= 1'b0;
         v1_r   <= 1'b0;
         exp0_r <= '0;
         exp1_r <= '0;
      end else begin
         v0_r <= pop_s;
         v1_r <= v0_r;
         if (pop_s) begin
            exp0_r <= head_s;
         end
         exp1_r <= exp0_r;
      end
   end

   // Failure reporting: pulse, sticky mask, saturating count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_r <= 1'b0;
         mask_r     <= '0;
         err_cnt_r  <= '0;
      end else begin
         mismatch_r <= cmp_fail_s;
         if (cmp_fail_s) begin
            mask_r <= q_fb ^ exp1_r;
            if (err_cnt_r != {ERR_CNT_W{1'b1}}) begin
               err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            end
         end
      end
   end

   assign j             = j_r;
   assign k             = k_r;
   assign busy          = (state_r == RUN) || (state_r == DRAIN);
   assign halted        = (state_r == HALT);
   assign mismatch      = mismatch_r;
   assign mismatch_mask = mask_r;
   assign err_count     = err_cnt_r;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: directed bench for jk_excitation_driver. Two
// instances share the target stream: u_dut_a halts on error, u_dut_b keeps
// running. Each drives its own behavioural JK bank with an injectable
// stuck-at-0 fault mask on the feedback.
module tb_jk_excitation_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tgt_valid = 1'b0;
   logic [3:0] tgt_data = 4'b0000;

   logic       tgt_ready_a, busy_a, halted_a, mismatch_a;
   logic [3:0] q_fb_a, j_a, k_a, mask_a, bank_a, fault_a;
   logic [7:0] err_a;
   logic       tgt_ready_b, busy_b, halted_b, mismatch_b;
   logic [3:0] q_fb_b, j_b, k_b, mask_b, bank_b, fault_b;
   logic [7:0] err_b;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   jk_excitation_driver #(.WIDTH(4), .DEPTH(4), .DC_VAL(1'b0), .STOP_ON_ERR(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
      .tgt_ready(tgt_ready_a), .q_fb(q_fb_a), .j(j_a), .k(k_a), .busy(busy_a),
      .halted(halted_a), .mismatch(mismatch_a), .mismatch_mask(mask_a), .err_count(err_a));

   jk_excitation_driver #(.WIDTH(4), .DEPTH(4), .DC_VAL(1'b0), .STOP_ON_ERR(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
      .tgt_ready(tgt_ready_b), .q_fb(q_fb_b), .j(j_b), .k(k_b), .busy(busy_b),
      .halted(halted_b), .mismatch(mismatch_b), .mismatch_mask(mask_b), .err_count(err_b));

   // JK banks: Q+ = J&~Q | ~K&Q, reset alongside the driver
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_a <= 4'b0000;
         bank_b <= 4'b0000;
      end else begin
         bank_a <= (j_a & ~bank_a) | (~k_a & bank_a);
         bank_b <= (j_b & ~bank_b) | (~k_b & bank_b);
      end
   end

   assign q_fb_a = bank_a & ~fault_a;
   assign q_fb_b = bank_b & ~fault_b;

   task automatic do_reset();
      rst_n     = 1'b0;
      tgt_valid = 1'b0;
      tgt_data  = 4'b0000;
      fault_a   = 4'b0000;
      fault_b   = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input bit use_b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!(use_b ? busy_b : busy_a)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({j_a, k_a, mask_a, err_a} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_regs: got j=%b k=%b mask=%b err=%0d want all zero", j_a, k_a, mask_a, err_a);
      end
      n_cmp++;
      if ({tgt_ready_a, busy_a, halted_a, mismatch_a} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got ready/busy/halted/mismatch=%b want 1000",
                  {tgt_ready_a, busy_a, halted_a, mismatch_a});
      end
   endtask

   task automatic test_basic_step();
      bit ok;
      do_reset();
      tgt_valid = 1'b1; tgt_data = 4'b1010;
      @(negedge clk);
      tgt_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy_a !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: got %b want 1", busy_a);
      end
      @(negedge clk);
      n_cmp++;
      if ({j_a, k_a} !== {4'b1010, 4'b0000}) begin
         n_fail++; $display("FAIL basic_jk: got j=%b k=%b want j=1010 k=0000", j_a, k_a);
      end
      @(negedge clk);
      n_cmp++;
      if ({j_a, k_a} !== 8'h00) begin
         n_fail++; $display("FAIL basic_hold: got j=%b k=%b want 0000/0000", j_a, k_a);
      end
      @(negedge clk);
      n_cmp++;
      if ({q_fb_a, mismatch_a} !== {4'b1010, 1'b0}) begin
         n_fail++; $display("FAIL basic_fb: got q=%b mismatch=%b want q=1010 mismatch=0", q_fb_a, mismatch_a);
      end
      wait_idle(1'b0, ok);
      n_cmp++;
      if ({ok, err_a} !== {1'b1, 8'd0}) begin
         n_fail++; $display("FAIL basic_idle: got idle=%b err=%0d want idle=1 err=0", ok, err_a);
      end
   endtask

   task automatic test_excitation_table();
      bit ok;
      do_reset();
      tgt_valid = 1'b1; tgt_data = 4'b1010;
      @(negedge clk);
      tgt_data = 4'b0110;
      @(negedge clk);
      tgt_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({j_a, k_a} !== {4'b1010, 4'b0000}) begin
         n_fail++; $display("FAIL exc_step1: got j=%b k=%b want j=1010 k=0000", j_a, k_a);
      end
      @(negedge clk);
      n_cmp++;
      if ({j_a, k_a} !== {4'b0100, 4'b1000}) begin
         n_fail++; $display("FAIL exc_step2: got j=%b k=%b want j=0100 k=1000", j_a, k_a);
      end
      wait_idle(1'b0, ok);
      n_cmp++;
      if ({ok, q_fb_a, err_a} !== {1'b1, 4'b0110, 8'd0}) begin
         n_fail++; $display("FAIL exc_settle: got idle=%b q=%b err=%0d want 1/0110/0", ok, q_fb_a, err_a);
      end
      tgt_valid = 1'b1; tgt_data = 4'b0110;
      @(negedge clk);
      tgt_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({busy_a, j_a, k_a} !== {1'b1, 4'b0000, 4'b0000}) begin
         n_fail++; $display("FAIL exc_same: got busy=%b j=%b k=%b want 1/0000/0000", busy_a, j_a, k_a);
      end
      wait_idle(1'b0, ok);
      n_cmp++;
      if ({ok, q_fb_a, err_a} !== {1'b1, 4'b0110, 8'd0}) begin
         n_fail++; $display("FAIL exc_same_end: got idle=%b q=%b err=%0d want 1/0110/0", ok, q_fb_a, err_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] tv [6];
      logic [7:0] ejk [6];
      bit ok;
      tv  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
      ejk = '{8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000, 8'b0000_0001, 8'b0000_0010};
      do_reset();
      for (int c = 0; c < 9; c++) begin
         if (c >= 3) begin
            n_cmp++;
            if ({j_a, k_a} !== ejk[c-3]) begin
               n_fail++; $display("FAIL b2b_jk%0d: got j/k=%b want %b", c-3, {j_a, k_a}, ejk[c-3]);
            end
         end
         if (c < 6) begin
            n_cmp++;
            if (tgt_ready_a !== 1'b1) begin
               n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", c, tgt_ready_a);
            end
            tgt_valid = 1'b1; tgt_data = tv[c];
         end else begin
            tgt_valid = 1'b0;
         end
         @(negedge clk);
      end
      wait_idle(1'b0, ok);
      n_cmp++;
      if ({ok, q_fb_a, err_a} !== {1'b1, 4'b1100, 8'd0}) begin
         n_fail++; $display("FAIL b2b_end: got idle=%b q=%b err=%0d want 1/1100/0", ok, q_fb_a, err_a);
      end
   endtask

   task automatic test_fault_halt();
      int pulses;
      int acc;
      bit jk_seen;
      do_reset();
      fault_a   = 4'b0001;
      tgt_valid = 1'b1; tgt_data = 4'b0001;
      @(negedge clk);
      tgt_valid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (mismatch_a === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_fail++; $display("FAIL halt_pulses: got %0d want 1", pulses);
      end
      n_cmp++;
      if ({mask_a, err_a, halted_a, busy_a} !== {4'b0001, 8'd1, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL halt_state: got mask=%b err=%0d halted=%b busy=%b want 0001/1/1/0",
                            mask_a, err_a, halted_a, busy_a);
      end
      acc = 0;
      jk_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tgt_valid = 1'b1; tgt_data = 4'(i + 2);
         if (tgt_ready_a === 1'b1) acc++;
         if ({j_a, k_a} !== 8'h00) jk_seen = 1'b1;
         @(negedge clk);
      end
      tgt_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({acc, tgt_ready_a} !== {32'd4, 1'b0}) begin
         n_fail++; $display("FAIL halt_fill: got accepted=%0d ready=%b want 4/0", acc, tgt_ready_a);
      end
      n_cmp++;
      if ({jk_seen, j_a, k_a, err_a, halted_a} !== {1'b0, 8'h00, 8'd1, 1'b1}) begin
         n_fail++; $display("FAIL halt_nopop: got jk_seen=%b j=%b k=%b err=%0d halted=%b want 0/0/0/1/1",
                            jk_seen, j_a, k_a, err_a, halted_a);
      end
   endtask

   task automatic test_fault_nostop();
      bit ok;
      do_reset();
      fault_b   = 4'b0001;
      tgt_valid = 1'b1; tgt_data = 4'b0001;
      @(negedge clk);
      tgt_data = 4'b0000;
      @(negedge clk);
      tgt_data = 4'b0001;
      n_cmp++;
      if (busy_b !== 1'b1) begin
         n_fail++; $display("FAIL nostop_busy: got %b want 1", busy_b);
      end
      @(negedge clk);
      tgt_valid = 1'b0;
      wait_idle(1'b1, ok);
      n_cmp++;
      if ({ok, err_b, mask_b, halted_b} !== {1'b1, 8'd2, 4'b0001, 1'b0}) begin
         n_fail++; $display("FAIL nostop_end: got idle=%b err=%0d mask=%b halted=%b want 1/2/0001/0",
                            ok, err_b, mask_b, halted_b);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      do_reset();
      fault_a   = 4'b0001;
      tgt_valid = 1'b1; tgt_data = 4'b0001;
      @(negedge clk);
      tgt_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (halted_a === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      for (int i = 0; i < 3; i++) begin
         tgt_valid = 1'b1; tgt_data = 4'(4'b1000 >> i);
         @(negedge clk);
      end
      tgt_valid = 1'b0;
      n_cmp++;
      if ({ok, err_a, mask_a} !== {1'b1, 8'd1, 4'b0001}) begin
         n_fail++; $display("FAIL midrst_pre: got halted=%b err=%0d mask=%b want 1/1/0001", ok, err_a, mask_a);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({j_a, k_a, err_a, mask_a, mismatch_a, halted_a} !== 22'h0) begin
         n_fail++; $display("FAIL midrst_async: got j=%b k=%b err=%0d mask=%b mis=%b halted=%b want zeros",
                            j_a, k_a, err_a, mask_a, mismatch_a, halted_a);
      end
      fault_a = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({busy_a, halted_a, tgt_ready_a, err_a, j_a, k_a} !== {1'b0, 1'b0, 1'b1, 8'd0, 8'h00}) begin
         n_fail++; $display("FAIL midrst_after: got busy=%b halted=%b ready=%b err=%0d j=%b k=%b want 0/0/1/0/0/0",
                            busy_a, halted_a, tgt_ready_a, err_a, j_a, k_a);
      end
   endtask

   initial begin
      fault_a = 4'b0000;
      fault_b = 4'b0000;
      test_reset();
      test_basic_step();
      test_excitation_table();
      test_back_to_back();
      test_fault_halt();
      test_fault_nostop();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
